// File: rtl/conv3x3_engine_pkg.sv
// Shared definitions for the 3x3 convolution engine: FSM state codes,
// kernel size and default image geometry.
package conv3x3_engine_pkg;

    localparam int CONV_KSIZE = 9;
    localparam int CONV_IMG_W = 12;
    localparam int CONV_IMG_H = 10;

    typedef enum logic [2:0] {
        CONV_IDLE  = 3'd0,
        CONV_FETCH = 3'd1,
        CONV_DRAIN = 3'd2,
        CONV_WRITE = 3'd3,
        CONV_DONE  = 3'd4
    } conv_state_e;

endpackage

// File: rtl/conv3x3_engine_mac.sv
// Multiply-accumulate block for the 3x3 convolution engine.
// Owns the wide accumulator and formats the result to DATA_W bits.
// Optional feature macro: CONV_SAT_EN (saturate instead of wrap).
module conv3x3_engine_mac #(
    parameter int DATA_W = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] pix,
    input  logic signed [DATA_W-1:0] coef,
    output logic signed [DATA_W-1:0] res_next
);

    localparam int PROD_W = 2 * DATA_W;
    // Four guard bits: nine full-width products can never overflow.
    localparam int ACC_W  = PROD_W + 4;

    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_next;
`ifdef CONV_SAT_EN
    logic [ACC_W-DATA_W:0]    acc_hi;
`endif

    // Next accumulator value; clear takes priority over accumulate.
    always_comb begin
        // NOTE: each combinationally assigned signal gets a default first, so no path can infer a latch.
        prod     = PROD_W'(pix) * PROD_W'(coef);
        acc_next = acc;
        if (clr) begin
            acc_next = '0;
        end else if (en) begin
            acc_next = acc + ACC_W'(prod);
        end
    end

    // Format the next accumulator value down to the result width.
    always_comb begin
`ifdef CONV_SAT_EN
        acc_hi = acc_next[ACC_W-1:DATA_W-1];
        if ((&acc_hi) || (~|acc_hi)) begin
            res_next = acc_next[DATA_W-1:0];
        end else if (acc_next[ACC_W-1]) begin
            res_next = {1'b1, {(DATA_W-1){1'b0}}};
        end else begin
            res_next = {1'b0, {(DATA_W-1){1'b1}}};
        end
`else
        res_next = acc_next[DATA_W-1:0];
`endif
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else begin
            // NOTE: sequential state is always updated with <= so every flop samples pre-edge values.
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/conv3x3_engine.sv
// 3x3 valid-region convolution engine. Holds a signed 3x3 kernel, walks a
// fixed image in a one-cycle-latency ROM and writes one result per 11 cycles.
// Optional feature macro: CONV_SAT_EN (saturating result format, in the MAC).
module conv3x3_engine
    import conv3x3_engine_pkg::*;
#(
    parameter int IMG_W  = CONV_IMG_W,
    parameter int IMG_H  = CONV_IMG_H,
    parameter int DATA_W = 32,
    parameter int IMG_AW = $clog2(IMG_W * IMG_H),
    parameter int RES_AW = $clog2((IMG_W - 2) * (IMG_H - 2))
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start_run,
    input  logic                     kernel_we,
    input  logic [3:0]               kernel_idx,
    input  logic signed [DATA_W-1:0] kernel_data,
    output logic [IMG_AW-1:0]        img_addr,
    input  logic signed [DATA_W-1:0] img_data,
    output logic                     res_we,
    output logic [RES_AW-1:0]        res_addr,
    output logic signed [DATA_W-1:0] res_data,
    output logic                     busy,
    output logic                     bonus_done
);

    localparam int RW    = $clog2(IMG_H);
    localparam int CW    = $clog2(IMG_W);
    localparam int OUT_W = IMG_W - 2;

    conv_state_e              state;
    logic                     start_q;
    logic                     start_edge;
    logic [RW-1:0]            r;
    logic [CW-1:0]            c;
    logic [3:0]               k;
    logic                     last_row;
    logic                     last_col;
    logic signed [DATA_W-1:0] kernel [CONV_KSIZE];
    logic [3:0]               coef_idx;
    logic signed [DATA_W-1:0] coef;
    logic                     mac_clr;
    logic                     mac_en;
    logic signed [DATA_W-1:0] mac_res;

    function automatic logic [IMG_AW-1:0] pix_addr(input int row, input int col);
        return IMG_AW'(row * IMG_W + col);
    endfunction

    assign start_edge = start_run && !start_q;
    assign last_row   = (r == RW'(IMG_H - 3));
    assign last_col   = (c == CW'(IMG_W - 3));

    // Kernel store: writable only while no run is in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the kernel is nine plain registers, not a RAM, so it is cleared on reset like any other state.
            for (int i = 0; i < CONV_KSIZE; i++) begin
                kernel[i] <= '0;
            end
        end else if (kernel_we && (kernel_idx < 4'(CONV_KSIZE)) &&
                     (state == CONV_IDLE || state == CONV_DONE)) begin
            kernel[kernel_idx] <= kernel_data;
        end
    end

    // MAC control: clear on the first fetch cycle, then accumulate the pixel
    // returned for the previous address against its kernel slot.
    always_comb begin
        mac_clr  = 1'b0;
        mac_en   = 1'b0;
        coef_idx = 4'(CONV_KSIZE - 1);
        if (state == CONV_FETCH) begin
            if (k == 4'd0) begin
                mac_clr = 1'b1;
            end else begin
                mac_en   = 1'b1;
                coef_idx = k - 4'd1;
            end
        end else if (state == CONV_DRAIN) begin
            mac_en = 1'b1;
        end
        coef = kernel[coef_idx];
    end

    conv3x3_engine_mac #(
        .DATA_W (DATA_W)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .clr      (mac_clr),
        .en       (mac_en),
        .pix      (img_data),
        .coef     (coef),
        .res_next (mac_res)
    );

    // Run FSM with address generation and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= CONV_IDLE;
            start_q    <= 1'b0;
            r          <= '0;
            c          <= '0;
            k          <= '0;
            img_addr   <= '0;
            res_we     <= 1'b0;
            res_addr   <= '0;
            res_data   <= '0;
            busy       <= 1'b0;
            bonus_done <= 1'b0;
        end else begin
            start_q <= start_run;
            res_we  <= 1'b0;
            unique case (state)
                CONV_IDLE: begin
                    if (start_edge) begin
                        state    <= CONV_FETCH;
                        busy     <= 1'b1;
                        r        <= '0;
                        c        <= '0;
                        k        <= '0;
                        img_addr <= '0;
                    end
                end
                CONV_FETCH: begin
                    if (!start_run) begin
                        state <= CONV_IDLE;
                        busy  <= 1'b0;
                    end else if (k == 4'(CONV_KSIZE - 1)) begin
                        state <= CONV_DRAIN;
                    end else begin
                        k        <= k + 4'd1;
                        img_addr <= pix_addr(int'(r) + (int'(k) + 1) / 3,
                                             int'(c) + (int'(k) + 1) % 3);
                    end
                end
                CONV_DRAIN: begin
                    if (!start_run) begin
                        state <= CONV_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state    <= CONV_WRITE;
                        res_we   <= 1'b1;
                        res_addr <= RES_AW'(int'(r) * OUT_W + int'(c));
                        res_data <= mac_res;
                    end
                end
                CONV_WRITE: begin
                    if (!start_run) begin
                        state <= CONV_IDLE;
                        busy  <= 1'b0;
                    end else if (last_row && last_col) begin
                        state      <= CONV_DONE;
                        busy       <= 1'b0;
                        bonus_done <= 1'b1;
                    end else begin
                        state <= CONV_FETCH;
                        k     <= '0;
                        if (last_col) begin
                            c        <= '0;
                            r        <= r + RW'(1);
                            img_addr <= pix_addr(int'(r) + 1, 0);
                        end else begin
                            c        <= c + CW'(1);
                            img_addr <= pix_addr(int'(r), int'(c) + 1);
                        end
                    end
                end
                CONV_DONE: begin
                    if (!start_run) begin
                        state      <= CONV_IDLE;
                        bonus_done <= 1'b0;
                    end
                end
                default: begin
                    state <= CONV_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Self-checking bench for conv3x3_engine: a reference convolution fills a
// scoreboard queue, and a monitor pops and compares on every result write.
module tb_conv3x3_engine;

    localparam int IMG_W  = 12;
    localparam int IMG_H  = 10;
    localparam int OW     = IMG_W - 2;
    localparam int OH     = IMG_H - 2;
    localparam int NPIX   = OW * OH;
    localparam int NIMG   = IMG_W * IMG_H;
    localparam int IMG_AW = $clog2(NIMG);
    localparam int RES_AW = $clog2(NPIX);

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } res_t;

    logic                clk;
    logic                rst;
    logic                start_run;
    logic                kernel_we;
    logic [3:0]          kernel_idx;
    logic signed [31:0]  kernel_data;
    logic [IMG_AW-1:0]   img_addr;
    logic signed [31:0]  img_data;
    logic                res_we;
    logic [RES_AW-1:0]   res_addr;
    logic signed [31:0]  res_data;
    logic                busy;
    logic                bonus_done;

    logic signed [31:0]  img [NIMG];
    logic signed [31:0]  kmod [9];
    res_t                exp_all [NPIX];
    res_t                exp_q [$];
    res_t                mon_e;
    int                  n_vec = 0;
    int                  n_err = 0;

    conv3x3_engine dut (
        .clk         (clk),
        .rst         (rst),
        .start_run   (start_run),
        .kernel_we   (kernel_we),
        .kernel_idx  (kernel_idx),
        .kernel_data (kernel_data),
        .img_addr    (img_addr),
        .img_data    (img_data),
        .res_we      (res_we),
        .res_addr    (res_addr),
        .res_data    (res_data),
        .busy        (busy),
        .bonus_done  (bonus_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Synchronous image ROM: data one cycle after the address.
    always @(posedge clk) img_data <= img[img_addr];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Result formatting from the arithmetic definition.
    function automatic logic [31:0] fmt(input logic signed [67:0] acc);
`ifdef CONV_SAT_EN
        if (acc > 68'sd2147483647) return 32'h7fff_ffff;
        if (acc < -68'sd2147483648) return 32'h8000_0000;
`endif
        return acc[31:0];
    endfunction

    // Reference valid-region convolution over the whole image.
    task automatic build_expected();
        logic signed [67:0] acc;
        logic signed [67:0] p;
        logic signed [67:0] q;
        for (int r = 0; r < OH; r++) begin
            for (int c = 0; c < OW; c++) begin
                acc = '0;
                for (int ki = 0; ki < 3; ki++) begin
                    for (int kj = 0; kj < 3; kj++) begin
                        p   = img[(r + ki) * IMG_W + (c + kj)];
                        q   = kmod[ki * 3 + kj];
                        acc = acc + p * q;
                    end
                end
                exp_all[r * OW + c].addr = r * OW + c;
                exp_all[r * OW + c].data = fmt(acc);
            end
        end
    endtask

    // Monitor: every result write is compared against the scoreboard head.
    always @(negedge clk) begin
        if (res_we) begin
            if (exp_q.size() == 0) begin
                check("unexpected_res_we", 64'(1), 64'(0));
            end else begin
                mon_e = exp_q.pop_front();
                check("res_addr", 64'(res_addr), 64'(mon_e.addr));
                check("res_data", {32'b0, res_data}, {32'b0, mon_e.data});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic kwrite(input logic [3:0] idx, input logic [31:0] val);
        tick();
        kernel_we   = 1'b1;
        kernel_idx  = idx;
        kernel_data = val;
        tick();
        kernel_we = 1'b0;
        if (idx < 4'd9) kmod[idx] = val;
    endtask

    task automatic set_kernel_all(input logic [31:0] val);
        for (int i = 0; i < 9; i++) kwrite(4'(i), val);
    endtask

    // One full run; optional kernel write on the start edge, optional
    // ignored write mid-run, and a hold of start_run after completion.
    task automatic do_run(input int hold, input bit s_we, input logic [3:0] s_idx,
                          input logic [31:0] s_val, input bit mid_wr);
        int cnt;
        if (s_we && s_idx < 4'd9) kmod[s_idx] = s_val;
        build_expected();
        for (int i = 0; i < NPIX; i++) exp_q.push_back(exp_all[i]);
        tick();
        start_run   = 1'b1;
        kernel_we   = s_we;
        kernel_idx  = s_idx;
        kernel_data = s_val;
        tick();
        kernel_we = 1'b0;
        check("busy_at_start", 64'(busy), 64'(1));
        cnt = 0;
        while (!bonus_done && cnt < 2000) begin
            tick();
            cnt++;
            if (mid_wr && cnt == 50) begin
                kernel_we   = 1'b1;
                kernel_idx  = 4'd4;
                kernel_data = $urandom;
            end
            if (mid_wr && cnt == 51) kernel_we = 1'b0;
        end
        check("run_cycles", 64'(cnt), 64'(11 * NPIX));
        check("busy_in_done", 64'(busy), 64'(0));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
        for (int i = 0; i < hold; i++) begin
            tick();
            check("done_held", 64'(bonus_done), 64'(1));
            check("no_restart", 64'(busy), 64'(0));
        end
        start_run = 1'b0;
        tick();
        check("done_cleared", 64'(bonus_done), 64'(0));
    endtask

    // Drop start_run after 100 cycles: only pixels whose write completed stay.
    task automatic do_abort();
        build_expected();
        for (int i = 0; i < 9; i++) exp_q.push_back(exp_all[i]);
        tick();
        start_run = 1'b1;
        tick();
        repeat (100) @(posedge clk);
        #1;
        start_run = 1'b0;
        check("abort_busy_before", 64'(busy), 64'(1));
        tick();
        check("abort_busy_after", 64'(busy), 64'(0));
        for (int i = 0; i < 30; i++) begin
            tick();
            check("abort_no_done", 64'(bonus_done), 64'(0));
        end
        check("abort_queue", 64'(exp_q.size()), 64'(0));
        exp_q.delete();
    endtask

    initial begin
        rst         = 1'b1;
        start_run   = 1'b0;
        kernel_we   = 1'b0;
        kernel_idx  = 4'd0;
        kernel_data = '0;
        for (int i = 0; i < 9; i++) kmod[i] = '0;
        for (int i = 0; i < NIMG; i++) img[i] = '0;
        repeat (3) tick();
        rst = 1'b0;
        check("rst_img_addr", 64'(img_addr), 64'(0));
        check("rst_res_addr", 64'(res_addr), 64'(0));
        check("rst_res_data", {32'b0, res_data}, 64'(0));
        check("rst_res_we", 64'(res_we), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_bonus_done", 64'(bonus_done), 64'(0));

        // Identity kernel over a ramp image.
        for (int i = 0; i < NIMG; i++) img[i] = i;
        set_kernel_all(32'd0);
        kwrite(4'd4, 32'd1);
        do_run(0, 1'b0, 4'd0, '0, 1'b0);

        // All-ones, then one negative coefficient against a bumped corner pixel.
        for (int i = 0; i < NIMG; i++) img[i] = 1;
        set_kernel_all(32'd1);
        do_run(0, 1'b0, 4'd0, '0, 1'b0);
        kwrite(4'd0, -32'sd3);
        img[0] = 5;
        do_run(0, 1'b0, 4'd0, '0, 1'b0);

        // Slot 8 written on the start edge; idx 9 is ignored.
        for (int i = 0; i < NIMG; i++) img[i] = $urandom_range(0, 1000);
        set_kernel_all(32'd0);
        kwrite(4'd9, 32'd77);
        do_run(0, 1'b1, 4'd8, 32'd2, 1'b0);

        // Extreme operands.
        for (int i = 0; i < NIMG; i++) img[i] = 32'h7fff_ffff;
        set_kernel_all(32'h7fff_ffff);
        do_run(0, 1'b0, 4'd0, '0, 1'b0);

        // Random full-range data, with an ignored mid-run kernel write.
        for (int i = 0; i < NIMG; i++) img[i] = $urandom;
        for (int i = 0; i < 9; i++) kwrite(4'(i), $urandom);
        do_run(0, 1'b0, 4'd0, '0, 1'b1);

        // Abort mid-run, then a fresh edge restarts from result 0.
        for (int i = 0; i < NIMG; i++) img[i] = $urandom_range(0, 200) - 100;
        for (int i = 0; i < 9; i++) kwrite(4'(i), $urandom_range(0, 20) - 10);
        do_abort();
        do_run(0, 1'b0, 4'd0, '0, 1'b0);

        // Completion handshake: start_run held high after done.
        do_run(20, 1'b0, 4'd0, '0, 1'b0);

        // Synchronous reset in the middle of a fetch.
        tick();
        start_run = 1'b1;
        repeat (5) tick();
        rst       = 1'b1;
        start_run = 1'b0;
        tick();
        check("midrst_img_addr", 64'(img_addr), 64'(0));
        check("midrst_res_addr", 64'(res_addr), 64'(0));
        check("midrst_res_data", {32'b0, res_data}, 64'(0));
        check("midrst_res_we", 64'(res_we), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_bonus_done", 64'(bonus_done), 64'(0));
        rst = 1'b0;
        for (int i = 0; i < 9; i++) kmod[i] = '0;
        for (int i = 0; i < NIMG; i++) img[i] = $urandom;
        do_run(0, 1'b0, 4'd0, '0, 1'b0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
